// File: rtl/osc_triangle_scheduler.sv
// osc_triangle_scheduler: period-driven triangle voices sharing one add/sub datapath through a round-robin arbiter.
// Optional OSC_TRIANGLE_SCHED_OVERRUN_EN adds sticky per-voice overrun flags.
module osc_triangle_scheduler #(
  parameter int NR_OF_VOICES_P       = 4,
  parameter int WAVE_WIDTH_P         = 24,
  parameter int PERIOD_WIDTH_P       = 32,
  parameter int WAVE_AMPLITUDE_INC_P = 1,
  parameter int WAVE_AMPLITUDE_MAX_P = 2**(WAVE_WIDTH_P-1)-1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cr_wr_en,
  input  logic [$clog2(NR_OF_VOICES_P)-1:0] cr_voice,
  input  logic [PERIOD_WIDTH_P-1:0]         cr_period,
  input  logic [NR_OF_VOICES_P-1:0]         cr_voice_en,
  output logic                              osc_valid,
  input  logic                              osc_ready,
  output logic [$clog2(NR_OF_VOICES_P)-1:0] osc_voice,
  output logic signed [WAVE_WIDTH_P-1:0]    osc_triangle,
  output logic [NR_OF_VOICES_P-1:0]         sr_overrun,
  input  logic                              cr_overrun_clr
);
  localparam int N = NR_OF_VOICES_P;
  localparam int VW = $clog2(NR_OF_VOICES_P);
  localparam int W = WAVE_WIDTH_P;
  localparam int P = PERIOD_WIDTH_P;
  localparam logic [P-1:0] P_ONE = P'(1);
  localparam logic signed [W-1:0] LOW = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] INC = W'(WAVE_AMPLITUDE_INC_P);
  localparam logic signed [W-1:0] MAX = W'(WAVE_AMPLITUDE_MAX_P);

  logic [P-1:0]        period_q [N];
  logic [P-1:0]        cnt_q    [N];
  logic [P-1:0]        reload   [N];
  logic signed [W-1:0] amp_q    [N];
  logic [N-1:0]        fall_q;
  logic [N-1:0]        pend_q;
  logic [VW-1:0]       ptr_q;
  logic [N-1:0]        wr_hit;
  logic [N-1:0]        tick;
  logic [N-1:0]        req;
  logic [N-1:0]        gnt_oh;
  logic                gnt_any;
  logic [VW-1:0]       gnt_idx;
  logic                stage_free;
  logic signed [W-1:0] cur_amp;
  logic signed [W-1:0] nxt_amp;
  logic                cur_fall;
  logic                nxt_fall;

  always_comb begin
    for (int v = 0; v < N; v++) begin
      wr_hit[v] = cr_wr_en && cr_voice == VW'(v);
      reload[v] = period_q[v] == '0 ? '0 : period_q[v] - P_ONE;
      tick[v]   = cr_voice_en[v] && !wr_hit[v] && cnt_q[v] == '0;
    end
  end

  // A voice whose enable just dropped must not win the arbiter with stale pending state.
  assign req = pend_q & cr_voice_en;
  assign stage_free = !osc_valid || osc_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (stage_free && !gnt_any && req[(int'(ptr_q) + i) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = VW'((int'(ptr_q) + i) % N);
      end
    end
    for (int v = 0; v < N; v++) gnt_oh[v] = gnt_any && gnt_idx == VW'(v);
  end

  always_comb begin
    cur_amp  = amp_q[gnt_idx];
    cur_fall = fall_q[gnt_idx];
    nxt_fall = cur_fall ? cur_amp != LOW : cur_amp >= MAX;
    nxt_amp  = nxt_fall ? cur_amp - INC : cur_amp + INC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < N; v++) begin
        period_q[v] <= '0;
        cnt_q[v]    <= '0;
        amp_q[v]    <= LOW;
      end
      fall_q       <= '0;
      pend_q       <= '0;
      ptr_q        <= '0;
      osc_valid    <= 1'b0;
      osc_voice    <= '0;
      osc_triangle <= LOW;
    end else begin
      for (int v = 0; v < N; v++) begin
        if (wr_hit[v]) begin
          period_q[v] <= cr_period;
          cnt_q[v]    <= cr_period == '0 ? '0 : cr_period - P_ONE;
        end else if (!cr_voice_en[v] || cnt_q[v] == '0) begin
          cnt_q[v] <= reload[v];
        end else begin
          cnt_q[v] <= cnt_q[v] - P_ONE;
        end
        if (gnt_oh[v]) begin
          amp_q[v]  <= nxt_amp;
          fall_q[v] <= nxt_fall;
        end
      end
      pend_q <= cr_voice_en & ((pend_q & ~gnt_oh) | tick);
      if (gnt_any) begin
        ptr_q        <= gnt_idx == VW'(N-1) ? '0 : gnt_idx + VW'(1);
        osc_valid    <= 1'b1;
        osc_voice    <= gnt_idx;
        osc_triangle <= nxt_amp;
      end else if (osc_ready) begin
        osc_valid <= 1'b0;
      end
    end
  end

`ifdef OSC_TRIANGLE_SCHED_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_overrun <= '0;
    else sr_overrun <= (sr_overrun & ~{N{cr_overrun_clr}}) | (tick & pend_q & ~gnt_oh);
  end
`else
  logic unused_clr;
  assign unused_clr = cr_overrun_clr;
  assign sr_overrun = '0;
`endif
endmodule
